// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the SPI byte-stream queue.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

   // Width of one SPI transfer unit.
   localparam int SPI_DATA_W = 8;

   // Transaction sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      GAP    = 2'd3
   } xfer_state_t;

   // Occupancy counters need one extra bit so that "full" (== depth) fits.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_fifo
// Description : Single-clock circular FIFO with first-word-fall-through read,
//               full/empty/level status and overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_fifo
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_DATA_W,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic [WIDTH-1:0]          pop_data,
   output logic                      full,
   output logic                      empty,
   output logic [level_w(DEPTH)-1:0] level,
   output logic                      ovf,
   output logic                      unf
);

   localparam int c_addr_w = $clog2(DEPTH);
   localparam int c_ptr_w  = c_addr_w + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic               w_push_ok;
   logic               w_pop_ok;

   // Pointers carry a wrap bit: same address with differing wrap bits is full.
   assign full  = (r_wptr[c_ptr_w-1] != r_rptr[c_ptr_w-1]) &&
                  (r_wptr[c_addr_w-1:0] == r_rptr[c_addr_w-1:0]);
   assign empty = (r_wptr == r_rptr);
   assign level = r_wptr - r_rptr;

   // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;
   assign ovf       = push && full;
   assign unf       = pop && empty;

   // Head word is presented combinationally; forced to zero when nothing is stored.
   assign pop_data = empty ? '0 : r_mem[r_rptr[c_addr_w-1:0]];

   // Storage write; contents need no reset because empty masks the read port.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr[c_addr_w-1:0]] <= push_data;
      end
   end

   // Pointer advance on accepted push/pop.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_queue.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_queue
// Description : Byte-stream front end for the SPI master. Queues TX bytes,
//               runs one single-byte transaction per byte via start/done,
//               and buffers received bytes for the user.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_queue
   import spi_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      wr_en,
   input  logic [SPI_DATA_W-1:0]     wr_data,
   output logic                      tx_full,
   output logic [level_w(DEPTH)-1:0] tx_level,
   input  logic                      rd_en,
   output logic [SPI_DATA_W-1:0]     rd_data,
   output logic                      rx_empty,
   output logic [level_w(DEPTH)-1:0] rx_level,
   output logic                      busy,
   output logic                      err_ovf,
   output logic                      err_unf,
   output logic                      err_tmo,
   input  logic                      clr_err,
   output logic                      spi_start,
   output logic [SPI_DATA_W-1:0]     spi_tx_data,
   input  logic [SPI_DATA_W-1:0]     spi_rx_data,
   input  logic                      spi_done
);

   // Counter only ever holds 0..TIMEOUT-1.
   localparam int                  c_cnt_w    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [c_cnt_w-1:0]  c_tmo_last = c_cnt_w'(TIMEOUT - 1);

   xfer_state_t            r_state;
   xfer_state_t            w_next_state;
   logic [c_cnt_w-1:0]     r_tmo_cnt;
   logic                   r_done_q;
   logic                   w_done_rise;

   logic                   w_tx_pop;
   logic                   w_rx_push;
   logic                   w_cnt_clr;
   logic                   w_cnt_inc;
   logic                   w_tmo_set;

   logic                   w_tx_empty;
   logic [SPI_DATA_W-1:0]  w_tx_head;
   logic                   w_tx_ovf;
   logic                   w_tx_unf;
   logic                   w_rx_full;
   logic                   w_rx_ovf;
   logic                   w_rx_unf;
   logic                   w_unused;

   spi_sync_fifo #(
      .WIDTH (SPI_DATA_W),
      .DEPTH (DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (w_tx_pop),
      .pop_data  (w_tx_head),
      .full      (tx_full),
      .empty     (w_tx_empty),
      .level     (tx_level),
      .ovf       (w_tx_ovf),
      .unf       (w_tx_unf)
   );

   spi_sync_fifo #(
      .WIDTH (SPI_DATA_W),
      .DEPTH (DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (w_rx_push),
      .push_data (spi_rx_data),
      .pop       (rd_en),
      .pop_data  (rd_data),
      .full      (w_rx_full),
      .empty     (rx_empty),
      .level     (rx_level),
      .ovf       (w_rx_ovf),
      .unf       (w_rx_unf)
   );

   // TX pops are always qualified and RX pushes are gated by RX space,
   // so these two pulses can never fire.
   assign w_unused = &{1'b0, w_tx_unf, w_rx_ovf};

   assign busy        = (r_state != IDLE);
   assign w_done_rise = spi_done && !r_done_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and per-state control strobes.
   always_comb begin
      w_next_state = r_state;
      w_tx_pop     = 1'b0;
      w_rx_push    = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_tmo_set    = 1'b0;
      spi_start    = 1'b0;
      case (r_state)
         IDLE: begin
            // A full RX FIFO holds off launches so no received byte is dropped.
            if (!w_tx_empty && !w_rx_full) begin
               w_tx_pop     = 1'b1;
               w_cnt_clr    = 1'b1;
               w_next_state = LAUNCH;
            end
         end
         LAUNCH: begin
            spi_start    = 1'b1;
            w_next_state = WAIT;
         end
         WAIT: begin
            // Only a fresh rising edge of done counts; a stale high level is ignored.
            if (w_done_rise) begin
               w_rx_push    = 1'b1;
               w_next_state = GAP;
            end else if (r_tmo_cnt == c_tmo_last) begin
               w_tmo_set    = 1'b1;
               w_next_state = GAP;
            end else begin
               w_cnt_inc    = 1'b1;
            end
         end
         GAP: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Byte handed to the master; held from LAUNCH until the next pop.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         spi_tx_data <= '0;
      end else if (w_tx_pop) begin
         spi_tx_data <= w_tx_head;
      end
   end

   // WAIT-cycle counter for the transaction timeout.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_tmo_cnt <= '0;
      end else if (w_cnt_clr) begin
         r_tmo_cnt <= '0;
      end else if (w_cnt_inc) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   // Delayed copy of done for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_done_q <= 1'b0;
      end else begin
         r_done_q <= spi_done;
      end
   end

   // Sticky error flags; a set in the same cycle as clr_err wins.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
         err_tmo <= 1'b0;
      end else begin
         if (w_tx_ovf) begin
            err_ovf <= 1'b1;
         end else if (clr_err) begin
            err_ovf <= 1'b0;
         end
         if (w_rx_unf) begin
            err_unf <= 1'b1;
         end else if (clr_err) begin
            err_unf <= 1'b0;
         end
         if (w_tmo_set) begin
            err_tmo <= 1'b1;
         end else if (clr_err) begin
            err_tmo <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
